// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the pc, pairs registered imem data with its pc and queues it toward decode.
// Optional FETCH_PERF_EN enables the perf_fetched / perf_squashed counters; otherwise both read as zero.
module fetch_unit #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_pc,
    input  logic [31:0]     imem_instr,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            dec_ready,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instruction,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_squashed
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inflight_q, pc_inflight_d;
    logic            inflight_q, inflight_d;
    logic [1:0]      count_q, count_d;
    entry_t          ent_q [2];
    entry_t          ent_d [2];

    logic            pop;
    logic            issue;
    logic [2:0]      occupancy;
    entry_t          new_ent;

    assign imem_pc        = pc_q;
    assign if_valid       = (count_q != 2'd0);
    assign if_pc          = ent_q[0].pc;
    assign if_instruction = ent_q[0].instr;

    // Entry 0 is always the head; it keeps its contents after the last pop so if_* hold when empty.
    always_comb begin
        pop       = if_valid & dec_ready;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = !redirect_valid && (occupancy < 3'd2);
        new_ent   = '{pc: pc_inflight_q, instr: imem_instr};

        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        inflight_d    = issue;
        count_d       = count_q;
        ent_d[0]      = ent_q[0];
        ent_d[1]      = ent_q[1];

        if (issue) begin
            pc_d          = pc_q + PC_W'(1);
            pc_inflight_d = pc_q;
        end

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            count_d = 2'd0;
        end else begin
            case ({inflight_q, pop})
                2'b10: begin
                    if (count_q == 2'd0) ent_d[0] = new_ent;
                    else                 ent_d[1] = new_ent;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) ent_d[0] = ent_q[1];
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent_d[0] = new_ent;
                    end else begin
                        ent_d[0] = ent_q[1];
                        ent_d[1] = new_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pc_inflight_q <= '0;
            inflight_q    <= 1'b0;
            count_q       <= 2'd0;
            ent_q[0]      <= '0;
            ent_q[1]      <= '0;
        end else begin
            pc_q          <= pc_d;
            pc_inflight_q <= pc_inflight_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            ent_q[0]      <= ent_d[0];
            ent_q[1]      <= ent_d[1];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;

    // A pop coinciding with a redirect is discarded, so it is counted as squashed rather than delivered.
    always_comb begin
        perf_fetched_d  = perf_fetched_q + {31'd0, pop & !redirect_valid};
        perf_squashed_d = perf_squashed_q;
        if (redirect_valid)
            perf_squashed_d = perf_squashed_q + {30'd0, count_q} + {31'd0, inflight_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q  <= 32'd0;
            perf_squashed_q <= 32'd0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`else
    assign perf_fetched  = 32'd0;
    assign perf_squashed = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem model, scoreboard of expected {pc, instr} deliveries,
// and per-scenario tasks covering reset, streaming, backpressure, redirects, pc wrap and reset mid-stall.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned exp_fetched = 0;
    int unsigned exp_squashed = 0;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(32), .RESET_PC(32'd0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .perf_fetched   (perf_fetched),
        .perf_squashed  (perf_squashed)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        case (pc)
            32'd0:   return 32'h0843_5555;
            32'd4:   return 32'h08C7_5555;
            32'd8:   return 32'h8046_000E;
            default: return {pc[15:0], ~pc[15:0]};
        endcase
    endfunction

    // imem with one-cycle registered read latency
    always @(posedge clk) imem_instr <= instr_of(imem_pc);

    task automatic expect_pcs(input logic [31:0] first, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = first + 32'(i);
            sb_q.push_back('{pc: p, instr: instr_of(p)});
        end
    endtask

    // Scores this cycle's handshake (if any), then advances to just after the next posedge.
    task automatic tick();
        exp_t e;
        if (!rst && if_valid && dec_ready && !redirect_valid) begin
            exp_fetched++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: delivered pc=%h instr=%h, required nothing", if_pc, if_instruction);
            end else begin
                e = sb_q.pop_front();
                if (if_pc !== e.pc || if_instruction !== e.instr) begin
                    errors++;
                    $display("FAIL sb_data: got pc=%h instr=%h, required pc=%h instr=%h",
                             if_pc, if_instruction, e.pc, e.instr);
                end else begin
                    $display("deliver pc=%h instr=%h", if_pc, if_instruction);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dec_ready = 1'b1;
        redirect_valid = 1'b0;
        sb_q.delete();
        exp_fetched = 0;
        exp_squashed = 0;
        tick();
        tick();
        checks++; if (imem_pc !== 32'd0) begin errors++; $display("FAIL rst_imem_pc: got %h required 0", imem_pc); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b required 0", if_valid); end
        checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL rst_if_pc: got %h required 0", if_pc); end
        checks++; if (if_instruction !== 32'd0) begin errors++; $display("FAIL rst_if_instr: got %h required 0", if_instruction); end
        checks++; if (perf_fetched !== 32'd0) begin errors++; $display("FAIL rst_perf_fetched: got %0d required 0", perf_fetched); end
        checks++; if (perf_squashed !== 32'd0) begin errors++; $display("FAIL rst_perf_squashed: got %0d required 0", perf_squashed); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        expect_pcs(32'd0, 10);
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (imem_pc !== 32'(c)) begin errors++; $display("FAIL stream_imem_pc: cycle %0d got %h required %h", c, imem_pc, c); end
            checks++;
            if (if_valid !== (c >= 2)) begin errors++; $display("FAIL stream_if_valid: cycle %0d got %b required %b", c, if_valid, c >= 2); end
            tick();
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL stream_drain: %0d left, required 0", sb_q.size()); end
    endtask

    task automatic test_backpressure();
        expect_pcs(32'd10, 8);
        dec_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== sb_q[0].pc || if_instruction !== sb_q[0].instr) begin
                errors++;
                $display("FAIL bp_head: stall %0d got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                         k, if_valid, if_pc, if_instruction, sb_q[0].pc, sb_q[0].instr);
            end
            checks++;
            if (imem_pc !== 32'd12) begin errors++; $display("FAIL bp_imem_pc: stall %0d got %h required 0000000c", k, imem_pc); end
            tick();
        end
        dec_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL bp_drain: %0d left, required 0", sb_q.size()); end
        checks++;
        if (perf_fetched !== (PERF ? 32'(exp_fetched) : 32'd0))
            begin errors++; $display("FAIL bp_perf_fetched: got %0d required %0d", perf_fetched, PERF ? exp_fetched : 0); end
    endtask

    // Redirect arrives with one entry buffered and one in flight, coincident with a would-be pop.
    task automatic test_redirect();
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL redir_pre_valid: got %b required 1", if_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 32'd14;
        exp_squashed += 2;
        tick();
        redirect_valid = 1'b0;
        sb_q.delete();
        expect_pcs(32'd14, 6);
        checks++; if (if_valid !== 1'b0 || imem_pc !== 32'd14) begin errors++; $display("FAIL redir_t1: got v=%b imem_pc=%h required v=0 imem_pc=0000000e", if_valid, imem_pc); end
        tick();
        checks++; if (if_valid !== 1'b0 || imem_pc !== 32'd15) begin errors++; $display("FAIL redir_t2: got v=%b imem_pc=%h required v=0 imem_pc=0000000f", if_valid, imem_pc); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd14) begin errors++; $display("FAIL redir_t3: got v=%b pc=%h required v=1 pc=0000000e", if_valid, if_pc); end
        for (int k = 0; k < 6; k++) tick();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL redir_drain: %0d left, required 0", sb_q.size()); end
        checks++;
        if (perf_fetched !== (PERF ? 32'(exp_fetched) : 32'd0))
            begin errors++; $display("FAIL redir_perf_fetched: got %0d required %0d", perf_fetched, PERF ? exp_fetched : 0); end
        checks++;
        if (perf_squashed !== (PERF ? 32'(exp_squashed) : 32'd0))
            begin errors++; $display("FAIL redir_perf_squashed: got %0d required %0d", perf_squashed, PERF ? exp_squashed : 0); end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc = 32'd40;
        exp_squashed += 2;
        tick();
        checks++; if (if_valid !== 1'b0 || imem_pc !== 32'd40) begin errors++; $display("FAIL b2b_first: got v=%b imem_pc=%h required v=0 imem_pc=00000028", if_valid, imem_pc); end
        redirect_pc = 32'd100;
        tick();
        redirect_valid = 1'b0;
        sb_q.delete();
        expect_pcs(32'd100, 4);
        checks++; if (if_valid !== 1'b0 || imem_pc !== 32'd100) begin errors++; $display("FAIL b2b_t1: got v=%b imem_pc=%h required v=0 imem_pc=00000064", if_valid, imem_pc); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL b2b_t2: got v=%b required 0", if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd100) begin errors++; $display("FAIL b2b_t3: got v=%b pc=%h required v=1 pc=00000064", if_valid, if_pc); end
        for (int k = 0; k < 4; k++) tick();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d left, required 0", sb_q.size()); end
        checks++;
        if (perf_squashed !== (PERF ? 32'(exp_squashed) : 32'd0))
            begin errors++; $display("FAIL b2b_perf_squashed: got %0d required %0d", perf_squashed, PERF ? exp_squashed : 0); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        exp_squashed += 2;
        tick();
        redirect_valid = 1'b0;
        sb_q.delete();
        expect_pcs(32'hFFFF_FFFE, 4);
        checks++; if (imem_pc !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_t1: got %h required fffffffe", imem_pc); end
        tick();
        checks++; if (imem_pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_t2: got %h required ffffffff", imem_pc); end
        tick();
        checks++; if (imem_pc !== 32'd0 || if_pc !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_t3: got imem_pc=%h if_pc=%h required 00000000 fffffffe", imem_pc, if_pc); end
        for (int k = 0; k < 4; k++) tick();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d left, required 0", sb_q.size()); end
        checks++;
        if (perf_squashed !== (PERF ? 32'(exp_squashed) : 32'd0))
            begin errors++; $display("FAIL wrap_perf_squashed: got %0d required %0d", perf_squashed, PERF ? exp_squashed : 0); end
    endtask

    task automatic test_reset_mid_stall();
        dec_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        sb_q.delete();
        exp_fetched = 0;
        exp_squashed = 0;
        checks++; if (if_valid !== 1'b0 || imem_pc !== 32'd0) begin errors++; $display("FAIL mrst_state: got v=%b imem_pc=%h required v=0 imem_pc=0", if_valid, imem_pc); end
        checks++; if (if_pc !== 32'd0 || if_instruction !== 32'd0) begin errors++; $display("FAIL mrst_head: got pc=%h instr=%h required 0 0", if_pc, if_instruction); end
        checks++; if (perf_fetched !== 32'd0 || perf_squashed !== 32'd0) begin errors++; $display("FAIL mrst_perf: got %0d %0d required 0 0", perf_fetched, perf_squashed); end
        rst = 1'b0;
        dec_ready = 1'b1;
        expect_pcs(32'd0, 3);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mrst_t0: got v=%b required 0", if_valid); end
        tick();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mrst_t1: got v=%b required 0", if_valid); end
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin errors++; $display("FAIL mrst_t2: got v=%b pc=%h required v=1 pc=0", if_valid, if_pc); end
        for (int k = 0; k < 3; k++) tick();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL mrst_drain: %0d left, required 0", sb_q.size()); end
        checks++;
        if (perf_fetched !== (PERF ? 32'(exp_fetched) : 32'd0))
            begin errors++; $display("FAIL mrst_perf_fetched: got %0d required %0d", perf_fetched, PERF ? exp_fetched : 0); end
    endtask

    initial begin
        rst = 1'b1;
        dec_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
